// File: rtl/z_result_queue_if.sv
// z_result_queue_if
//   Bundles the control, data and status signals between the ALU side and
//   the Z result queue.
//   Parameters: WIDTH (data width), DEPTH (entries, power of 2, >= 2).
//   Signals:
//     ZControl  2      00 idle, 01 drive (pop), 10 load (push), 11 load+drive
//     ZInput    WIDTH  data pushed on load
//     flush     1      discard all queued entries
//     err_clr   1      clear sticky error flags
//     ZOutput   WIDTH  last value driven out of the queue (registered)
//     empty     1      no entries held
//     full      1      DEPTH entries held
//     count     CW     entries currently held
//     ovf_err   1      sticky: load attempted while full
//     unf_err   1      sticky: drive attempted while empty
//   Modports: master (ALU / controller side), slave (queue side).
interface z_result_queue_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [1:0]       ZControl;
    logic [WIDTH-1:0] ZInput;
    logic             flush;
    logic             err_clr;
    logic [WIDTH-1:0] ZOutput;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf_err;
    logic             unf_err;

    modport master (
        output ZControl, ZInput, flush, err_clr,
        input  ZOutput, empty, full, count, ovf_err, unf_err
    );

    modport slave (
        input  ZControl, ZInput, flush, err_clr,
        output ZOutput, empty, full, count, ovf_err, unf_err
    );
endinterface

// File: rtl/z_result_queue.sv
// z_result_queue
//   FIFO of ALU results between the ALU and register-file write-back.
//   Keeps the legacy 2-bit Z load/drive encoding; adds ordering, combined
//   load+drive (with bypass when empty), flush, occupancy and sticky errors.
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset (highest priority)
//     zq   - z_result_queue_if.slave bundle (control, data, status)
module z_result_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    z_result_queue_if.slave   zq
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic is_empty;
    logic is_full;
    logic push;
    logic pop;
    logic bypass;
    logic ovf_set;
    logic unf_set;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Status comes from the registered count only.
    assign zq.empty = is_empty;
    assign zq.full  = is_full;
    assign zq.count = count_q;

    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        bypass  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!zq.flush) begin
            case (zq.ZControl)
                2'b10: begin
                    if (is_full) ovf_set = 1'b1;
                    else         push    = 1'b1;
                end
                2'b01: begin
                    if (is_empty) unf_set = 1'b1;
                    else          pop     = 1'b1;
                end
                2'b11: begin
                    // Empty queue: the incoming word goes straight out.
                    // Otherwise (full included) push and pop together.
                    if (is_empty) begin
                        bypass = 1'b1;
                    end else begin
                        push = 1'b1;
                        pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; a push while full is only possible together
    // with a pop, which reads the old entry before it is overwritten.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= zq.ZInput;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            zq.ZOutput <= '0;
            zq.ovf_err <= 1'b0;
            zq.unf_err <= 1'b0;
        end else begin
            // A newly raised error wins over err_clr in the same cycle.
            zq.ovf_err <= ovf_set | (zq.ovf_err & ~zq.err_clr);
            zq.unf_err <= unf_set | (zq.unf_err & ~zq.err_clr);
            if (zq.flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr     <= rd_ptr + 1'b1;
                    zq.ZOutput <= mem[rd_ptr];
                end
                if (bypass) zq.ZOutput <= zq.ZInput;
                if (push && !pop)      count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
        end
    end
endmodule
